// File: rtl/flt2int_seq_if.sv
// Data-memory port of the float->int sequencer, plus its busy/done status.
interface flt2int_seq_if #(
  parameter int unsigned AW = 8
);
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_wr_en;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          done;

  modport master (
    output mem_addr, mem_wr_en, mem_wdata, busy, done,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wr_en, mem_wdata, busy, done,
    output mem_rdata
  );
endinterface

// File: rtl/flt2int_seq.sv
// Half-precision float -> 16-bit sign-magnitude integer converter driving a byte-wide data memory.
// Reads the operand, shifts the mantissa one bit per cycle, writes the truncated result and raises done.
module flt2int_seq #(
  parameter int unsigned AW       = 8,
  parameter int unsigned IN_ADDR  = 64,
  parameter int unsigned OUT_ADDR = 66
) (
  input  logic              clk,
  input  logic              reset,
  flt2int_seq_if.master     bus
);

  typedef enum logic [2:0] {
    IDLE, RD_HI, RD_LO, DECODE, SHIFT, WR_HI, WR_LO, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] f;
  logic        sgn;
  logic [14:0] acc;
  logic [3:0]  n;
  logic        left;

  logic [4:0]  exp_b;
  logic [10:0] man;
  logic [14:0] dec_acc;
  logic [3:0]  dec_n;
  logic        dec_left;

  assign exp_b = f[14:10];
  assign man   = {|exp_b, f[9:0]};

  // Biased exponent 25 is the binary point of the 11-bit mantissa (e = E-15 = 10).
  always_comb begin
    dec_acc  = '0;
    dec_n    = '0;
    dec_left = 1'b0;
    if (exp_b >= 5'd30) begin
      dec_acc = '1;
    end else if (exp_b >= 5'd15) begin
      dec_acc = {4'b0000, man};
      if (exp_b <= 5'd25) begin
        dec_n = 4'(5'd25 - exp_b);
      end else begin
        dec_n    = 4'(exp_b - 5'd25);
        dec_left = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      f     <= '0;
      sgn   <= 1'b0;
      acc   <= '0;
      n     <= '0;
      left  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        RD_HI:  f[15:8] <= bus.mem_rdata;
        RD_LO:  f[7:0]  <= bus.mem_rdata;
        DECODE: begin
          sgn  <= f[15];
          acc  <= dec_acc;
          n    <= dec_n;
          left <= dec_left;
        end
        SHIFT: begin
          acc <= left ? {acc[13:0], 1'b0} : {1'b0, acc[14:1]};
          n   <= n - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.mem_addr  = '0;
    bus.mem_wr_en = 1'b0;
    bus.mem_wdata = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE:   state_nxt = RD_HI;
      RD_HI: begin
        bus.mem_addr = AW'(IN_ADDR);
        bus.busy     = 1'b1;
        state_nxt    = RD_LO;
      end
      RD_LO: begin
        bus.mem_addr = AW'(IN_ADDR + 1);
        bus.busy     = 1'b1;
        state_nxt    = DECODE;
      end
      DECODE: begin
        bus.busy  = 1'b1;
        state_nxt = (dec_n == 4'd0) ? WR_HI : SHIFT;
      end
      SHIFT: begin
        bus.busy  = 1'b1;
        state_nxt = (n == 4'd1) ? WR_HI : SHIFT;
      end
      WR_HI: begin
        bus.mem_addr  = AW'(OUT_ADDR);
        bus.mem_wr_en = 1'b1;
        bus.mem_wdata = {sgn & (|acc), acc[14:8]};
        bus.busy      = 1'b1;
        state_nxt     = WR_LO;
      end
      WR_LO: begin
        bus.mem_addr  = AW'(OUT_ADDR + 1);
        bus.mem_wr_en = 1'b1;
        bus.mem_wdata = acc[7:0];
        bus.busy      = 1'b1;
        state_nxt     = DONE;
      end
      DONE:    bus.done = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flt2int_seq.sv
// Directed and random checks of flt2int_seq against a byte memory model and a truncating reference.
module tb_flt2int_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] mem [0:255];
  int unsigned wr_count = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flt2int_seq_if #(.AW(8)) bus ();

  flt2int_seq #(.AW(8), .IN_ADDR(64), .OUT_ADDR(66)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Value = m * 2^(E-25), truncated toward zero; saturates for E >= 30.
  function automatic logic [15:0] ref_conv(input logic [15:0] v);
    int e = int'(v[14:10]);
    int m = (e != 0) ? (1024 + int'(v[9:0])) : int'(v[9:0]);
    int mag;
    if (e >= 30)      mag = 32767;
    else if (e < 15)  mag = 0;
    else              mag = int'((longint'(m) * (longint'(1) << e)) >> 25);
    return {v[15] && (mag != 0), 15'(mag)};
  endfunction

  function automatic int ref_done(input logic [15:0] v);
    int e = int'(v[14:10]);
    if (e >= 15 && e <= 29) return 5 + ((e > 25) ? e - 25 : 25 - e);
    return 5;
  endfunction

  task automatic hold_reset(input logic [15:0] op);
    reset = 1'b1;
    mem[64] = op[15:8];
    mem[65] = op[7:0];
    mem[66] = 8'hA5;
    mem[67] = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  // Cycle 0 is the first cycle after the clock edge that sees reset low.
  task automatic run_case(input string tag, input logic [15:0] op, input logic [15:0] exp,
                          input int exp_done);
    int cyc;
    int unsigned wr_base;
    hold_reset(op);
    reset = 1'b0;
    wr_base = wr_count;
    @(posedge clk); #1;
    cyc = 0;
    check({tag, "_busy0"}, int'(bus.busy), 1);
    while (!bus.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == exp_done - 1) check({tag, "_busy_last"}, int'(bus.busy), 1);
    end
    check({tag, "_done_cyc"}, cyc, exp_done);
    check({tag, "_result"}, int'({mem[66], mem[67]}), int'(exp));
    check({tag, "_writes"}, int'(wr_count - wr_base), 2);
    check({tag, "_busy_done"}, int'(bus.busy), 0);
  endtask

  initial begin
    logic [15:0] op;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    hold_reset(16'h0000);
    check("rst_addr", int'(bus.mem_addr), 0);
    check("rst_wr_en", int'(bus.mem_wr_en), 0);
    check("rst_wdata", int'(bus.mem_wdata), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);

    run_case("c2_04", 16'hC204, 16'h8003, 14);
    run_case("ca10", 16'hCA10, 16'h800C, 12);
    run_case("5a40", 16'h5A40, 16'h00C8, 8);
    run_case("pinf", 16'h7C00, 16'h7FFF, 5);
    run_case("ninf", 16'hFC00, 16'hFFFF, 5);
    run_case("p0999", 16'h3BFF, 16'h0000, 5);
    run_case("n0999", 16'hBBFF, 16'h0000, 5);
    run_case("one", 16'h3C00, 16'h0001, 15);
    run_case("max_l", 16'h77FF, 16'h7FF0, 9);
    run_case("nan", 16'h7E01, 16'h7FFF, 5);

    // Abort during SHIFT: cycle 4 of 0xCA10 is inside SHIFT (cycles 3..9).
    hold_reset(16'hCA10);
    reset = 1'b0;
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_done", int'(bus.done), 0);
    check("abort_busy", int'(bus.busy), 0);
    repeat (12) begin @(posedge clk); #1; end
    check("abort_mem", int'({mem[66], mem[67]}), 16'hA55A);
    run_case("rerun", 16'hCA10, 16'h800C, 12);

    for (int k = 0; k < 100; k++) begin
      op = 16'($urandom);
      run_case($sformatf("rnd%0d_%04h", k, op), op, ref_conv(op), ref_done(op));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
